// File: rtl/eq_stim_driver_if.sv
// Bus between the equivalence-miter stimulus driver and whatever controls it.
// The controller (master) starts runs and forwards the miter trigger; the
// driver (slave) returns the stimulus vector and the run results.
interface eq_stim_driver_if #(
    parameter int IN_W  = 5,
    parameter int CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] max_cycles;
    logic             trigger;
    logic [IN_W-1:0]  stim;
    logic             busy;
    logic             done;
    logic             fail;
    logic [CNT_W-1:0] fail_cycle;
    logic [IN_W-1:0]  fail_vec;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output start, max_cycles, trigger,
        input  stim, busy, done, fail, fail_cycle, fail_vec, cycle_count
    );

    modport slave (
        input  start, max_cycles, trigger,
        output stim, busy, done, fail, fail_cycle, fail_vec, cycle_count
    );
endinterface

// File: rtl/eq_stim_driver.sv
// eq_stim_driver: drives Galois-LFSR vectors into the miter, watches its
// trigger and freezes on the first mismatch, recording the failing cycle
// index and the vector that was driven LAT cycles earlier.
module eq_stim_driver #(
    parameter int          IN_W   = 5,
    parameter int          CNT_W  = 16,
    parameter int          LAT    = 1,
    parameter int          WARMUP = 2,
    parameter logic [31:0] SEED   = 32'h1
) (
    input  logic            clk,
    input  logic            rst,
    eq_stim_driver_if.slave bus
);
    // A zero seed would lock the LFSR at zero forever.
    localparam logic [31:0]      SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [CNT_W-1:0] LAT_C    = CNT_W'(LAT);
    localparam logic [CNT_W-1:0] WARM_C   = CNT_W'(WARMUP);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [31:0]      r_lfsr;
    logic [IN_W-1:0]  r_hist [0:LAT];
    logic [CNT_W-1:0] r_remain;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_failCycle;
    logic [IN_W-1:0]  r_failVec;
    logic             r_fail;
    logic             w_active;
    logic             w_startOk;
    logic             w_failNow;
    logic             w_lastStep;
    logic [IN_W-1:0]  w_stimNext;

    function automatic logic [31:0] lfsrNext(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    // State register; reset always returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_stateNext;
    end

    // Next-state decode plus status outputs; r_count doubles as the cycle index.
    always_comb begin
        w_active    = (r_state == S_RUN) || (r_state == S_DRAIN);
        w_startOk   = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
        w_failNow   = w_active && bus.trigger && (r_count >= WARM_C);
        w_lastStep  = (r_remain == CNT_ONE);
        w_stimNext  = ((r_state == S_RUN) && !w_lastStep) ? r_lfsr[IN_W-1:0] : r_hist[0];
        w_stateNext = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_startOk) w_stateNext = (bus.max_cycles == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (w_failNow)       w_stateNext = S_DONE;
                else if (w_lastStep) w_stateNext = (LAT == 0) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                if (w_failNow || w_lastStep) w_stateNext = S_DONE;
            end
            default: w_stateNext = S_IDLE;
        endcase
        bus.busy = w_active;
        bus.done = (r_state == S_DONE);
    end

    // Datapath: LFSR, vector history, run/drain countdown, counters and capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr      <= SEED_EFF;
            for (int j = 0; j <= LAT; j++) r_hist[j] <= '0;
            r_remain    <= '0;
            r_count     <= '0;
            r_fail      <= 1'b0;
            r_failCycle <= '0;
            r_failVec   <= '0;
        end else if (w_startOk) begin
            if (bus.max_cycles == '0) begin
                r_fail  <= 1'b0;
                r_count <= '0;
            end else begin
                r_lfsr      <= lfsrNext(SEED_EFF);
                r_hist[0]   <= SEED_EFF[IN_W-1:0];
                for (int j = 1; j <= LAT; j++) r_hist[j] <= '0;
                r_remain    <= bus.max_cycles;
                r_count     <= '0;
                r_fail      <= 1'b0;
                r_failCycle <= '0;
                r_failVec   <= '0;
            end
        end else if (w_active) begin
            r_count <= (r_count == CNT_MAX) ? r_count : r_count + 1'b1;
            if (w_failNow) begin
                r_fail      <= 1'b1;
                r_failCycle <= r_count;
                r_failVec   <= r_hist[LAT];
            end else begin
                r_hist[0] <= w_stimNext;
                for (int j = 1; j <= LAT; j++) r_hist[j] <= r_hist[j-1];
                if ((r_state == S_RUN) && w_lastStep) r_remain <= LAT_C;
                else                                  r_remain <= r_remain - 1'b1;
                if ((r_state == S_RUN) && !w_lastStep) r_lfsr <= lfsrNext(r_lfsr);
            end
        end
    end

    assign bus.stim        = r_hist[0];
    assign bus.fail        = r_fail;
    assign bus.fail_cycle  = r_failCycle;
    assign bus.fail_vec    = r_failVec;
    assign bus.cycle_count = r_count;
endmodule

// File: doc/eq_stim_driver.md
# eq_stim_driver

Stimulus-and-capture engine for the equivalence miter: drives pseudo-random input vectors into the miter's data inputs each clock, watches the miter's `trigger` output, and on the first mismatch freezes and records the failing cycle index and the vector that caused it. It sits on the opposite side of the miter from the compared netlists, with shared `clk`. It replaces ad-hoc testbench loops so fuzz runs are self-checking and reproducible from a seed.

## Interface
- `IN_W`, default 5: stimulus vector width, 1..32.
- `CNT_W`, default 16: width of the cycle counters and `max_cycles`.
- `LAT`, default 1: cycles between a vector being driven and its effect appearing on `trigger`, 0..15.
- `WARMUP`, default 2: number of initial run cycles during which `trigger` is ignored. Must be ≥ `LAT`.
- `SEED`, default 32'h1: LFSR seed. A value of 0 is replaced by 1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset. Synchronous, active-high.
- `start`, in, 1: begin a run. Accepted only in IDLE or DONE.
- `max_cycles`, in, `CNT_W`: number of vectors to drive. Sampled when `start` is accepted.
- `trigger`, in, 1: miter mismatch flag; 1 means mismatch.
- `stim`, out, `IN_W`: vector driven into the miter inputs.
- `busy`, out, 1: high in RUN and DRAIN.
- `done`, out, 1: high in DONE.
- `fail`, out, 1: a mismatch was captured during the last run.
- `fail_cycle`, out, `CNT_W`: cycle index at which `trigger` was seen.
- `fail_vec`, out, `IN_W`: vector driven `LAT` cycles before the failure.
- `cycle_count`, out, `CNT_W`: number of RUN+DRAIN cycles elapsed in the current or last run.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- Reset (any state): go to IDLE. Every output becomes 0 on the edge where `rst`=1. LFSR reloads `SEED`, history clears.
- LFSR: 32-bit Galois, right shift. Next state = (s>>1) ^ (s[0] ? 32'h80200003 : 0). `stim` = s[IN_W-1:0].
- IDLE/DONE + `start`:
  - if `max_cycles`==0: go to DONE; `fail`=0, `cycle_count`=0; `stim` unchanged.
  - otherwise: go to RUN; LFSR reloads `SEED`; `fail`, `fail_cycle`, `fail_vec` and `cycle_count` clear.
- RUN: the cycle index i starts at 0 in the first RUN cycle. In cycle i, `stim` = LFSR state i; the LFSR advances every cycle. After `max_cycles` RUN cycles:
  - if `LAT`=0: go to DONE;
  - otherwise: go to DRAIN.
- DRAIN: lasts `LAT` cycles. `stim` holds the last vector and i keeps incrementing. Then go to DONE.
- History: a shift register of the last `LAT`+1 driven vectors.
- Failure check: in RUN/DRAIN, at the edge ending cycle i, a failure occurs if i ≥ `WARMUP` and `trigger`==1. On failure:
  - `fail`=1, `fail_cycle`=i, `fail_vec`=vector driven at index i−`LAT`;
  - go to DONE immediately, skipping any remaining RUN/DRAIN;
  - `stim` freezes.
  - Only the first failure per run is captured.
- `cycle_count` = i+1 after each RUN/DRAIN cycle. It saturates at all-ones and never wraps.
- `start` in RUN/DRAIN is ignored. `start` and `rst` together: `rst` wins.
- DONE holds `done`=1 and all results until `start` or `rst`.
- `stim` is 0 in IDLE and holds its last value in DONE.

## Timing
- `start` sampled at edge k: `busy`=1 and `stim` = SEED low bits from edge k onward (visible in cycle k+1).
- Normal run length: exactly `max_cycles`+`LAT` cycles with `busy`=1, then `done`=1 on the following edge.
- Failure at index i: `done`=1, `busy`=0 and `fail`=1 are all visible starting the cycle after edge i.
- `trigger` is consumed combinationally from the miter and registered only into the state and capture registers. No combinational path from `trigger` to any output.
- Zero-length start: `done` rises one cycle after `start`.

## Test plan
- Reset: assert `rst` 1 cycle → all outputs 0 and the block is in IDLE; `start` is not accepted while `rst`=1.
- `SEED`=1, `IN_W`=5, `LAT`=1, `max_cycles`=4, `trigger`=0 → `stim` = 1, 3, 2, 1, then holds 1 for 1 DRAIN cycle. `done`=1, `fail`=0, `cycle_count`=5.
- `LAT`=1, `WARMUP`=2, `max_cycles`=100, `trigger` pulsed high during index 6 → `fail`=1, `fail_cycle`=6, `fail_vec` = vector at index 5, `done` the next cycle, `stim` frozen, `cycle_count`=7.
- `trigger`=1 only at index 1 with `WARMUP`=2 → ignored; run completes with `fail`=0.
- `max_cycles`=0 → `done` one cycle after `start`, `busy` never rises, `stim` unchanged.
- `rst` at RUN index 3 → all outputs 0 next cycle. `start` pulsed mid-RUN (no reset) → no restart; counts continue uninterrupted.
